// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and width helper for the fifo write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Width of an index into n requesters; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker starting after the last grantee
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_id_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_id_o,
    output logic               any_valid_o
);

    // Scan last_id_i+1, last_id_i+2, ... wrapping; the first set request wins.
    always_comb begin
        logic [IDW-1:0] idx;
        grant_o     = '0;
        grant_id_o  = last_id_i;
        any_valid_o = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last_id_i) + k) % NUM_REQ);
            if (!any_valid_o && req_i[idx]) begin
                any_valid_o = 1'b1;
                grant_id_o  = idx;
                grant_o     = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// rtl/fifo_rr_write_arbiter.sv - round-robin bounded-burst arbiter for the shared fifo write port
module fifo_rr_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                           clkIn,
    input  logic                           resetIn,
    input  logic [NUM_REQ-1:0]             reqValidIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  reqDataIn,
    output logic [NUM_REQ-1:0]             reqReadyOut,
    input  logic                           fifoFullIn,
    output logic                           fifoWriteEnableOut,
    output logic [DATA_WIDTH-1:0]          fifoDataOut,
    output logic [NUM_REQ-1:0]             grantOut,
    output logic [$clog2(NUM_REQ)-1:0]     grantIdOut,
    output logic                           busyOut
);

    localparam int IDW = idx_width(NUM_REQ);
    localparam int BW  = $clog2(BURST_MAX + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [BW-1:0]      beat_q, beat_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;

    logic               in_burst;
    logic               g_valid;
    logic               transfer;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req_i       (reqValidIn),
        .last_id_i   (grant_id_q),
        .grant_o     (pick_grant),
        .grant_id_o  (pick_id),
        .any_valid_o (pick_any)
    );

    // Datapath towards the fifo and per-requester handshake for the current grantee.
    always_comb begin
        in_burst           = (state_q == ST_BURST);
        g_valid            = reqValidIn[grant_id_q];
        transfer           = in_burst && g_valid && !fifoFullIn && !resetIn;
        fifoWriteEnableOut = transfer;
        fifoDataOut        = in_burst ? reqDataIn[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH]
                                      : '0;
        reqReadyOut        = (in_burst && !fifoFullIn && !resetIn) ? grant_q : '0;
        grantOut           = grant_q;
        grantIdOut         = grant_id_q;
        busyOut            = in_burst;
    end

    // Next-state: arbitrate in IDLE, count beats in BURST, leave on BURST_MAX or a dry requester.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        beat_d     = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_BURST;
                    grant_d    = pick_grant;
                    grant_id_d = pick_id;
                    beat_d     = '0;
                end
            end
            ST_BURST: begin
                if (!g_valid) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (transfer) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BW'(BURST_MAX - 1)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset points the rotation at the last requester so requester 0 goes first.
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= IDW'(NUM_REQ - 1);
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            beat_q     <= beat_d;
        end
    end

endmodule
